// File: rtl/mux_arb_if.sv
// Bundle between N producer channels, the arbitrating mux and its single consumer.
// The mux side uses the slave modport; the driving environment uses master.
interface mux_arb_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4
);
  localparam int unsigned SELW = (N > 1) ? $clog2(N) : 1;

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [SELW-1:0]    sel;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SELW-1:0]    out_sel;

  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_valid, out_sel
  );

  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_valid, out_sel
  );
endinterface

// File: rtl/mux_arb.sv
// N-channel arbitrating mux with one registered valid/ready output stage.
// MODE 0: fixed priority (lowest index), 1: round-robin, 2: explicit select.
module mux_arb #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  parameter int unsigned MODE  = 0
) (
  input logic      clk,
  input logic      rst,
  mux_arb_if.slave bus
);
  localparam int unsigned SELW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     eligible_c;
  logic [N-1:0]     above_c;
  logic [N-1:0]     masked_c;
  logic [N-1:0]     pick_c;
  logic [N-1:0]     ready_c;
  logic [SELW-1:0]  grant_c;
  logic             grant_any_c;
  logic             load_en_c;
  logic [WIDTH-1:0] grant_data_c;

  logic [WIDTH-1:0] out_data_r;
  logic [SELW-1:0]  out_sel_r;
  logic             out_valid_r;
  logic [SELW-1:0]  rr_ptr;

  assign load_en_c = !out_valid_r || bus.out_ready;

  // Eligible set: every valid channel, or only the selected one in MODE 2.
  always_comb begin
    eligible_c = bus.in_valid;
    if (MODE == 2) begin
      for (int i = 0; i < int'(N); i++) begin
        eligible_c[i] = bus.in_valid[i] && (bus.sel == SELW'(i));
      end
    end
  end

  // Round-robin as a two-pass priority pick: channels at or above rr_ptr first,
  // then wrap to the full eligible set.
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      above_c[i] = (SELW'(i) >= rr_ptr);
    end
    masked_c = eligible_c & above_c;
    pick_c   = ((MODE == 1) && (masked_c != '0)) ? masked_c : eligible_c;
  end

  always_comb begin
    grant_c = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (pick_c[i]) grant_c = SELW'(i);
    end
  end

  assign grant_any_c = |eligible_c;

  // in_ready never depends on in_data; the data mux only feeds the register.
  always_comb begin
    ready_c      = '0;
    grant_data_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (grant_c == SELW'(i)) begin
        ready_c[i]   = load_en_c && grant_any_c && !rst;
        grant_data_c = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sel_r   <= '0;
      rr_ptr      <= '0;
    end else if (load_en_c) begin
      out_valid_r <= grant_any_c;
      if (grant_any_c) begin
        out_data_r <= grant_data_c;
        out_sel_r  <= grant_c;
        if (MODE == 1) begin
          rr_ptr <= (grant_c == SELW'(N - 1)) ? '0 : grant_c + SELW'(1);
        end
      end
    end
  end

  assign bus.in_ready  = ready_c;
  assign bus.out_data  = out_data_r;
  assign bus.out_sel   = out_sel_r;
  assign bus.out_valid = out_valid_r;
endmodule

// File: doc/mux_arb.md
# mux_arb

Parametrised N-channel arbitrating multiplexer with a registered, valid/ready-handshaked output, successor to the fixed 4-input combinational mux in the MIPS datapath. It selects one of N producer channels per cycle (fixed priority, round-robin, or explicit select), holds the winner in a single output register, and applies backpressure to the producers. It is used wherever several pipeline sources share one consumer, e.g. instruction-fetch and load/store requests sharing a memory port.

## Interface
- WIDTH, 32, data width per channel
- N, 4, number of input channels (N ≥ 1)
- MODE, 0, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin, 2 = explicit select via `sel`
- SELW (localparam), max(1, clog2(N)), select/channel-index width

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  N  channel i presents data
- in_ready  out  N  channel i transfer accepted this cycle
- sel  in  SELW  channel to select; used only when MODE = 2
- out_data  out  WIDTH  registered data of the granted channel
- out_valid  out  1  out_data holds a valid word
- out_ready  in  1  consumer accepts out_data this cycle
- out_sel  out  SELW  index of the channel whose data is in out_data

## Operation
- `load_en = !out_valid || out_ready`: the output register may accept a new word this cycle.
- Eligible set: `in_valid` in MODE 0 and 1. In MODE 2, only bit `sel` is eligible. If `sel` ≥ N, no channel is eligible.
- Grant:
  - MODE 0: lowest-index eligible channel.
  - MODE 1: first eligible channel scanning from `rr_ptr` upward, wrapping modulo N.
  - MODE 2: `sel` when eligible.
- `in_ready[g] = load_en && eligible[g]` for the granted g only. All other `in_ready` bits are 0. At most one `in_ready` bit is high per cycle.
- `in_ready` is combinational from `in_valid`, `sel`, `out_valid` and `out_ready`. There is no combinational path from `in_data`.
- Transfer on channel g (`in_valid[g] && in_ready[g]`): next cycle `out_data = in_data[g]`, `out_sel = g`, `out_valid = 1`.
- `load_en` with no grant: `out_valid` goes to 0. `out_data` and `out_sel` hold their previous values.
- `out_valid && !out_ready`: `out_data`, `out_sel` and `out_valid` hold. All `in_ready` bits are 0.
- Round-robin pointer (MODE 1 only): after a transfer from g, `rr_ptr = (g+1) mod N`. With no transfer it holds. In other modes `rr_ptr` stays 0.
- N = 1: the block degenerates to a single registered pipeline stage. `out_sel` is constantly 0.

## Timing
- Reset (synchronous, `rst` = 1 at a rising edge): `out_valid = 0`, `out_data = 0`, `out_sel = 0`, `rr_ptr = 0`. While `rst` is high, all `in_ready` bits are 0.
- Reset mid-operation: a held word is discarded without a handshake. No transfer occurs in the reset cycle.
- Latency: 1 cycle from input transfer to `out_valid`.
- Throughput: 1 word/cycle when `out_ready` is held high.
- Simultaneous output drain and input load in the same cycle (`out_valid && out_ready` with a grant) is required. There is no bubble.
- Once `out_valid` is high, `out_data` is stable until the cycle after `out_valid && out_ready`.
- Changing `sel` in MODE 2 does not affect a word already held in the output register.

## Test plan
- Reset and idle: assert `rst` 2 cycles with `in_valid = 4'b1111` -> `in_ready = 0`, `out_valid = 0`, `out_data = 0`. After release with all `in_valid = 0` -> `out_valid` stays 0.
- Fixed priority, MODE 0, N = 4, `out_ready = 1`, `in_valid = 4'b1010`, ch1 = 0x11, ch3 = 0x33 -> `in_ready = 4'b0010`. Next cycle `out_data = 0x11`, `out_sel = 1`. Ch3 is served only after ch1 drops valid.
- Round-robin, MODE 1, all four channels valid continuously, data = 0xA0+i, `out_ready = 1` -> `out_sel` sequence 0,1,2,3,0 on consecutive cycles, `out_data` 0xA0,0xA1,0xA2,0xA3,0xA0, no bubbles.
- Backpressure: `out_valid = 1` with 0x55, hold `out_ready = 0` for 3 cycles while ch2 is valid -> `out_data` stays 0x55 and `in_ready = 0`. When `out_ready` is raised, ch2 transfers that cycle and `out_data` = ch2 data on the next cycle.
- Explicit select, MODE 2, N = 3, `sel = 2` with only ch0 valid -> no grant, `out_valid` 0. `sel = 3` with all channels valid -> no grant. `sel = 0` -> ch0 transfers.
- Reset mid-hold: `out_valid = 1`, `out_ready = 0`, pulse `rst` 1 cycle -> next cycle `out_valid = 0`, `out_data = 0`, `out_sel = 0`, `rr_ptr = 0`.
